// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath types and constants.
// Register file bypass is selected with REGFILE_BYPASS_EN.
package rv32i_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RF_AW = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Register file clear sequencer: walks every index once after reset.
// Build option: REGFILE_BYPASS_EN (used by the parent only).
module regfile_clear_seq
  import rv32i_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cidx_q, cidx_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cidx_q  <= cidx_d;
    busy_q  <= busy_d;
  end

  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    busy_d  = busy_q;
    if (rst) begin
      state_d = RF_CLEAR;
      cidx_d  = '0;
      busy_d  = 1'b1;
    end else begin
      unique case (state_q)
        RF_CLEAR: begin
          cidx_d = cidx_q + 1'b1;
          if (cidx_q == AW'(NREGS - 1)) begin
            state_d = RF_READY;
            busy_d  = 1'b0;
          end
        end
        RF_READY: ;
        default: ;
      endcase
    end
  end

  assign ready   = (state_q == RF_READY);
  assign busy    = busy_q;
  assign clr_we  = (state_q == RF_CLEAR) && !rst;
  assign clr_idx = cidx_q;

endmodule

// File: rtl/regfile_2r1w_clr.sv
// 2R1W register file with registered reads and sequential clear.
// Define REGFILE_BYPASS_EN for write-first same-cycle reads.
module regfile_2r1w_clr
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] data_in,
  input  logic            RegWrite,
  input  logic            read_en,
  output logic [XLEN-1:0] data_1,
  output logic [XLEN-1:0] data_2,
  output logic            busy
);

  logic [XLEN-1:0] regs [NREGS];
  logic            ready;
  logic            clr_we;
  logic [AW-1:0]   clr_idx;
  logic            wr_en;
  logic [XLEN-1:0] rd1_val, rd2_val;

  regfile_clear_seq #(.NREGS(NREGS)) u_clr (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_en = ready && !rst && RegWrite
              && (rd != AW'(ZERO_REG));

  // Clear strobe owns the write port while the sequence runs
  always_ff @(posedge clk) begin
    if (clr_we)
      regs[clr_idx] <= '0;
    else if (wr_en)
      regs[rd] <= data_in;
  end

  always_comb begin
    rd1_val = (rs1 == AW'(ZERO_REG)) ? '0 : regs[rs1];
    rd2_val = (rs2 == AW'(ZERO_REG)) ? '0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && rd == rs1) rd1_val = data_in;
    if (wr_en && rd == rs2) rd2_val = data_in;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || !ready) begin
      data_1 <= '0;
      data_2 <= '0;
    end else if (read_en) begin
      data_1 <= rd1_val;
      data_2 <= rd2_val;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Scoreboard bench for regfile_2r1w_clr (32x32 and 64x16 builds).
module tb_regfile_2r1w_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, RegWrite, read_en, busy;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] data_in, data_1, data_2;

  logic        b_rst, b_we, b_re, b_busy;
  logic [3:0]  b_rs1, b_rs2, b_rd;
  logic [63:0] b_din, b_d1, b_d2;

  regfile_2r1w_clr dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .data_in(data_in), .RegWrite(RegWrite), .read_en(read_en),
    .data_1(data_1), .data_2(data_2), .busy(busy)
  );

  regfile_2r1w_clr #(.XLEN(64), .NREGS(16)) dut64 (
    .clk(clk), .rst(b_rst), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .data_in(b_din), .RegWrite(b_we), .read_en(b_re),
    .data_1(b_d1), .data_2(b_d2), .busy(b_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mdl [32];
  logic [31:0] last1, last2;
  logic [63:0] sb [$];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_exp(logic [4:0] a,
      logic we, logic [4:0] w, logic [31:0] d);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && w == a) return d;
`endif
    return mdl[a];
  endfunction

  task automatic clr_mdl;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    last1 = '0;
    last2 = '0;
  endtask

  task automatic cyc(string tag, logic we, logic [4:0] w,
      logic [31:0] d, logic re, logic [4:0] a, logic [4:0] b);
    logic [31:0] e1, e2;
    logic [63:0] p;
    RegWrite = we; rd = w; data_in = d;
    read_en = re; rs1 = a; rs2 = b;
    e1 = re ? rd_exp(a, we, w, d) : last1;
    e2 = re ? rd_exp(b, we, w, d) : last2;
    sb.push_back({e1, e2});
    last1 = e1;
    last2 = e2;
    if (we && w != 5'd0) mdl[w] = d;
    step;
    RegWrite = 1'b0;
    read_en = 1'b0;
    p = sb.pop_front();
    check({tag, "/d1"}, 64'(data_1), 64'(p[63:32]));
    check({tag, "/d2"}, 64'(data_2), 64'(p[31:0]));
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step;
      n++;
      if (!busy) break;
    end
  endtask

  initial begin
    int n;
    logic [4:0] w, a, b;
    logic [31:0] d;
    logic we, re;
    rst = 1'b1; RegWrite = 1'b0; read_en = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; data_in = '0;
    b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0;
    b_rs1 = '0; b_rs2 = '0; b_rd = '0; b_din = '0;
    step;
    step;
    check("rst_d1", 64'(data_1), 64'd0);
    check("rst_d2", 64'(data_2), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    wait_clear(n);
    check("clear_len", 64'(n), 64'd32);
    clr_mdl();

    cyc("pre5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    wait_clear(n);
    check("reclear_len", 64'(n), 64'd32);
    clr_mdl();
    cyc("r5", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);

    cyc("pre20", 1'b1, 5'd20, 32'h00001234, 1'b0, 5'd0, 5'd0);
    cyc("pre3", 1'b1, 5'd3, 32'h00000333, 1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    repeat (10) step;
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    RegWrite = 1'b1; rd = 5'd9; data_in = 32'hFFFF0000;
    wait_clear(n);
    RegWrite = 1'b0;
    check("mid_len", 64'(n), 64'd32);
    clr_mdl();
    for (int i = 0; i < 32; i++)
      cyc("allzero", 1'b0, 5'd0, 32'd0, 1'b1,
          5'(i), 5'(31 - i));

    cyc("w0", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
    cyc("r0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    cyc("w3", 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0);
    cyc("r3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);

    cyc("w7", 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd0);
    cyc("same", 1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 5'd3);
    cyc("after", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);

    cyc("w4", 1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 5'd0);
    cyc("w6", 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd0);
    cyc("r4", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd6);
    cyc("hold", 1'b1, 5'd4, 32'h44, 1'b0, 5'd6, 5'd4);
    cyc("unhold", 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd4);

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 3) != 0);
      w = 5'($urandom_range(0, 7));
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      d = $urandom;
      cyc("rand", we, w, d, re, a, b);
    end

    b_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step;
      n++;
      if (!b_busy) break;
    end
    check("w64_len", 64'(n), 64'd16);
    b_we = 1'b1; b_rd = 4'd5; b_din = 64'hDEADBEEF_CAFEF00D;
    step;
    b_rd = 4'd15; b_din = 64'h0123456789ABCDEF;
    step;
    b_we = 1'b0; b_re = 1'b1; b_rs1 = 4'd5; b_rs2 = 4'd15;
    step;
    b_re = 1'b0;
    check("w64_d1", b_d1, 64'hDEADBEEF_CAFEF00D);
    check("w64_d2", b_d2, 64'h0123456789ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_clr.md
# regfile_2r1w_clr

Parametrised two-read/one-write integer register file for the RV32I core datapath, sitting between decode (source/destination indices) and the execute/writeback stages. It generalises register width and count and keeps a one-cycle registered read. It adds a synchronous reset that sequentially zeroes every register under a busy flag, plus a read-enable hold for pipeline stalls.

## Interface
- XLEN, 32, register and data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- AW, $clog2(NREGS), index width (localparam, not overridable)

- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset; synchronous, active-high
- rs1  in  AW  read port 1 index
- rs2  in  AW  read port 2 index
- rd  in  AW  write index
- data_in  in  XLEN  write data
- RegWrite  in  1  write enable
- read_en  in  1  1 = capture new read data; 0 = hold data_1/data_2
- data_1  out  XLEN  registered read data, port 1
- data_2  out  XLEN  registered read data, port 2
- busy  out  1  1 while the clear sequence runs; writes are ignored while high

## Operation
- The block has two states, CLEAR and READY, and an AW-bit clear index `cidx`.
- rst=1 at an edge:
  - state <= CLEAR, cidx <= 0, busy <= 1, data_1 <= 0, data_2 <= 0.
  - Holding rst keeps the block parked at cidx 0.
- CLEAR with rst=0, each edge:
  - regs[cidx] <= 0; cidx <= cidx+1.
  - At cidx == NREGS-1: state <= READY, busy <= 0 on the same edge.
- CLEAR: RegWrite is dropped, and data_1/data_2 are forced to 0 regardless of read_en.
- READY, write: RegWrite=1 and rd != 0 -> regs[rd] <= data_in. A write to index 0 is discarded, so register 0 always reads 0.
- READY, read with read_en=1:
  - data_1 <= (rs1==0) ? 0 : regs[rs1]; likewise data_2 from rs2.
- READY, read with read_en=0: data_1/data_2 keep their values. Writes still proceed.
- Same-cycle write and read of one nonzero index: the result is set by the macro (see Configuration).
- Both read ports may address the same index with no conflict.
- Reset mid-clear: the sequence restarts from cidx 0 and takes the full NREGS cycles.

## Timing
- Reset values:
  - data_1 = 0, data_2 = 0, busy = 1.
  - Every register reads 0 once busy falls.
- Clear duration: busy is high for exactly NREGS edges after the first edge with rst=0. For NREGS=32, busy falls on the 32nd edge.
- Read latency: 1 cycle. Indices sampled at edge N appear on data_x after edge N.
- Write latency: 1 cycle. A write at edge N is visible to a read sampled at edge N+1.
- An index of NREGS or above cannot occur, because NREGS is a power of two.
- RegWrite=1 on the cycle busy falls: the write is accepted only on edges where state is READY at the start of the cycle.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first): in READY with read_en=1, RegWrite=1, rd!=0 and rsX==rd, data_X <= data_in in the same edge.
- Undefined (read-first): data_X <= the old regs[rsX]. The new value is visible from the next read.
- The macro has no effect on the clear sequence or on register 0.

## Structure
- Shared package `rv32i_pkg`:
  - XLEN default and register-index width constant.
  - Index of register 0 (ZERO_REG).
  - State enum `rf_state_t` {RF_CLEAR, RF_READY}.
- Sub-module `regfile_clear_seq`:
  - Holds the state register, cidx counter and busy.
  - Outputs a clear-write strobe and its index.
  - The parent muxes the clear-write strobe/index over the RegWrite/rd path.
- Storage is a plain XLEN x NREGS array with no per-entry reset (synthesises to LUTRAM/flops).

## Test plan
- Reset clear:
  - Preload reg 5=0xDEADBEEF, pulse rst 1 cycle.
  - busy high exactly 32 cycles, then read rs1=5 -> data_1=0x00000000.
- Reset mid-clear: assert rst at cidx=10 -> busy stays high for a further full 32 cycles after rst drops, and all registers read 0.
- Register 0 and basic read/write:
  - Write rd=0 data 0x12345678 -> rs1=0 reads 0.
  - Write rd=3 0xA5A5A5A5 -> next cycle rs1=3, rs2=3 -> both outputs 0xA5A5A5A5.
- Same-cycle write/read:
  - reg 7=0x1, then RegWrite rd=7 0x2 with rs1=7.
  - With REGFILE_BYPASS_EN: data_1=0x2. Without: data_1=0x1, and the following read gives 0x2.
- Stall hold:
  - data_1=0x11 from reg 4; drop read_en, change rs1 to 6 (=0x66) and write reg 4=0x44 -> data_1 stays 0x11.
  - Raise read_en -> data_1=0x66.
- Write during busy:
  - RegWrite rd=9 0xFFFF0000 while busy=1 -> after busy falls, rs1=9 reads 0.
  - Parameter sweep XLEN=64, NREGS=16: busy lasts 16 cycles and 64-bit data round-trips.
